// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Brief    : Shared types and constants for the writeback port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int         WB_XLEN  = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Brief    : Small LLU result FIFO exposing per-slot valid/rd for lookups.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [4:0]           push_rd,
  input  logic [XLEN-1:0]      push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [4:0]           head_rd,
  output logic [XLEN-1:0]      head_data,
  output logic [DEPTH-1:0]     slot_valid,
  output logic [DEPTH*5-1:0]   slot_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [DEPTH-1:0] r_valid;
  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];

  logic w_push;
  logic w_pop;

  assign full  = (r_count == c_full_count);
  assign empty = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign head_rd    = r_rd[r_rptr];
  assign head_data  = r_data[r_rptr];
  assign slot_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Push and pop never target the same slot: that needs empty-and-full at once.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[i] <= 1'b0;
          r_rd[i]    <= '0;
          r_data[i]  <= '0;
        end else begin
          if (w_pop && (r_rptr == PW'(i))) r_valid[i] <= 1'b0;
          if (w_push && (r_wptr == PW'(i))) begin
            r_valid[i] <= 1'b1;
            r_rd[i]    <= push_rd;
            r_data[i]  <= push_data;
          end
        end
      end
      assign slot_rd[i*5 +: 5] = r_rd[i];
    end
  endgenerate

endmodule : wb_result_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the RF write port between pipeline writeback and LLU results.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_wb_en,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            llu_valid,
  input  logic [4:0]      llu_rd,
  input  logic [XLEN-1:0] llu_data,
  output logic            llu_ready,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic            rd_pending,
  output logic            stall_req,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] c_max_age = AW'(MAX_WAIT);

  logic              w_full;
  logic              w_empty;
  logic [4:0]        w_head_rd;
  logic [XLEN-1:0]   w_head_data;
  logic [DEPTH-1:0]  w_slot_valid;
  logic [DEPTH*5-1:0] w_slot_rd;

  logic              w_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_stall;
  logic              w_pipe_sel;
  logic              w_pop;
  logic [AW-1:0]     r_age;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_rd    (llu_rd),
    .push_data  (llu_data),
    .pop        (w_pop),
    .full       (w_full),
    .empty      (w_empty),
    .head_rd    (w_head_rd),
    .head_data  (w_head_data),
    .slot_valid (w_slot_valid),
    .slot_rd    (w_slot_rd)
  );

  // Every output is gated by rst_n so reset takes effect without a clock.
  assign w_ready    = rst_n & ~w_full;
  assign w_accept   = llu_valid & w_ready;
  assign w_push     = w_accept & (llu_rd != REG_ZERO);
  assign w_stall    = rst_n & ~w_empty & (r_age == c_max_age);
  assign w_pipe_sel = rst_n & ~w_stall & pipe_wb_en & (pipe_rd != REG_ZERO);
  assign w_pop      = w_stall | (rst_n & ~w_pipe_sel & ~w_empty);

  assign llu_ready = w_ready;
  assign stall_req = w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_empty || w_pop) begin
      r_age <= '0;
    end else if (r_age != c_max_age) begin
      r_age <= r_age + 1'b1;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (w_pop) begin
      rf_we    = 1'b1;
      rf_waddr = w_head_rd;
      rf_wdata = w_head_data;
    end else if (w_pipe_sel) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_data;
    end
  end

  function automatic logic is_pending(
    input logic [4:0]         q,
    input logic [DEPTH-1:0]   vld,
    input logic [DEPTH*5-1:0] rds,
    input logic               acc,
    input logic [4:0]         lrd
  );
    logic hit;
    hit = acc && (lrd == q);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (rds[i*5 +: 5] == q)) hit = 1'b1;
    end
    return (q != REG_ZERO) && hit;
  endfunction

  assign rs1_pending = is_pending(q_rs1, w_slot_valid, w_slot_rd, w_accept, llu_rd);
  assign rs2_pending = is_pending(q_rs2, w_slot_valid, w_slot_rd, w_accept, llu_rd);
  assign rd_pending  = is_pending(q_rd,  w_slot_valid, w_slot_rd, w_accept, llu_rd);

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Vector table, directed corner sequences and a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int XLEN     = 32;

  logic            clk;
  logic            rst_n;
  logic            pipe_wb_en;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            llu_valid;
  logic [4:0]      llu_rd;
  logic [XLEN-1:0] llu_data;
  logic            llu_ready;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            rd_pending;
  logic            stall_req;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  wb_port_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT),
    .XLEN     (XLEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_wb_en  (pipe_wb_en),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .llu_valid   (llu_valid),
    .llu_rd      (llu_rd),
    .llu_data    (llu_data),
    .llu_ready   (llu_ready),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rd_pending  (rd_pending),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: accepted LLU results in arrival order, plus head age.
  wb_req_t m_q[$];
  int      m_age = 0;
  logic    m_pop;
  logic            e_we, e_ready, e_stall, e_p1, e_p2, e_pd;
  logic [4:0]      e_waddr;
  logic [XLEN-1:0] e_wdata;

  logic            s_we, s_ready, s_stall, s_p1, s_p2, s_pd;
  logic [4:0]      s_waddr;
  logic [XLEN-1:0] s_wdata;

  typedef struct {
    logic pwe; logic [4:0] prd; logic [31:0] pdata;
    logic lv;  logic [4:0] lrd; logic [31:0] ldata;
    logic [4:0] q1; logic [4:0] q2; logic [4:0] qd;
    logic we;  logic [4:0] waddr; logic [31:0] wdata;
    logic rdy; logic stl; logic p1; logic p2; logic pd;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    pipe_wb_en = pwe; pipe_rd = prd; pipe_data = pd;
    llu_valid  = lv;  llu_rd  = lrd; llu_data  = ld;
    q_rs1 = r1; q_rs2 = r2; q_rd = rd;
  endtask

  function automatic logic model_pending(input logic [4:0] q);
    logic hit;
    hit = llu_valid && e_ready && (llu_rd == q);
    foreach (m_q[i]) if (m_q[i].rd == q) hit = 1'b1;
    return (q != 5'd0) && hit;
  endfunction

  task automatic model_eval();
    e_ready = (m_q.size() < DEPTH);
    e_stall = (m_age == MAX_WAIT) && (m_q.size() != 0);
    e_we = 1'b0; e_waddr = 5'd0; e_wdata = '0; m_pop = 1'b0;
    if (e_stall) begin
      e_we = 1'b1; e_waddr = m_q[0].rd; e_wdata = m_q[0].data; m_pop = 1'b1;
    end else if (pipe_wb_en && (pipe_rd != 5'd0)) begin
      e_we = 1'b1; e_waddr = pipe_rd; e_wdata = pipe_data;
    end else if (m_q.size() != 0) begin
      e_we = 1'b1; e_waddr = m_q[0].rd; e_wdata = m_q[0].data; m_pop = 1'b1;
    end
    e_p1 = model_pending(q_rs1);
    e_p2 = model_pending(q_rs2);
    e_pd = model_pending(q_rd);
  endtask

  task automatic model_update();
    wb_req_t r;
    logic was_empty;
    was_empty = (m_q.size() == 0);
    if (m_pop) m_q.delete(0);
    if (llu_valid && e_ready && (llu_rd != 5'd0)) begin
      r.rd = llu_rd; r.data = llu_data;
      m_q.push_back(r);
    end
    if (was_empty || m_pop) m_age = 0;
    else if (m_age < MAX_WAIT) m_age++;
  endtask

  // Called at posedge+1 with inputs already set; returns at next posedge+1.
  task automatic run_cycle();
    model_eval();
    @(negedge clk);
    s_we = rf_we; s_waddr = rf_waddr; s_wdata = rf_wdata;
    s_ready = llu_ready; s_stall = stall_req;
    s_p1 = rs1_pending; s_p2 = rs2_pending; s_pd = rd_pending;
    check("model_write", 64'({s_we, s_waddr, s_wdata}), 64'({e_we, e_waddr, e_wdata}));
    check("model_ctrl",  64'({s_ready, s_stall}), 64'({e_ready, e_stall}));
    check("model_pend",  64'({s_p1, s_p2, s_pd}), 64'({e_p1, e_p2, e_pd}));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(rf_we), 64'd0);
    check({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
    check({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
    check({tag, "_ready"}, 64'(llu_ready), 64'd0);
    check({tag, "_stall"}, 64'(stall_req), 64'd0);
    check({tag, "_pend"},  64'({rs1_pending, rs2_pending, rd_pending}), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[1]  = '{1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd0, 1, 5'd5, 32'h1234, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 5'd0, 32'h55,   0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[3]  = '{0, 5'd0, 32'h0,    1, 5'd7, 32'hCAFE, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[4]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd7, 5'd7, 5'd0, 1, 5'd7, 32'hCAFE, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd7, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[6]  = '{0, 5'd0, 32'h0,    1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[7]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};
    tbl[8]  = '{1, 5'd4, 32'h44,   1, 5'd9, 32'h99,   5'd0, 5'd0, 5'd9, 1, 5'd4, 32'h44,   1, 0, 0, 0, 1};
    tbl[9]  = '{1, 5'd4, 32'h45,   0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd9, 1, 5'd4, 32'h45,   1, 0, 0, 0, 1};
    tbl[10] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd9, 1, 5'd9, 32'h99,   1, 0, 0, 0, 1};
    tbl[11] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    5'd0, 5'd0, 5'd9, 0, 5'd0, 32'h0,    1, 0, 0, 0, 0};

    // Reset held with busy inputs: everything must read zero.
    rst_n = 1'b0;
    set_in(1, 5'd5, 32'h1234, 1, 5'd7, 32'hCAFE, 5'd7, 5'd7, 5'd7);
    #12;
    check_reset_outputs("reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].pwe, tbl[i].prd, tbl[i].pdata, tbl[i].lv, tbl[i].lrd, tbl[i].ldata,
             tbl[i].q1, tbl[i].q2, tbl[i].qd);
      run_cycle();
      check($sformatf("tbl%0d_write", i), 64'({s_we, s_waddr, s_wdata}),
            64'({tbl[i].we, tbl[i].waddr, tbl[i].wdata}));
      check($sformatf("tbl%0d_ctrl", i), 64'({s_ready, s_stall, s_p1, s_p2, s_pd}),
            64'({tbl[i].rdy, tbl[i].stl, tbl[i].p1, tbl[i].p2, tbl[i].pd}));
    end

    // Starvation: one buffered entry while the pipeline writes every cycle.
    set_in(1, 5'd2, 32'h100, 1, 5'd11, 32'hB0B, 5'd0, 5'd0, 5'd0);
    run_cycle();
    for (int i = 0; i < MAX_WAIT; i++) begin
      set_in(1, 5'd2, 32'h101 + 32'(i), 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      run_cycle();
      check("starve_pipe_wr", 64'({s_stall, s_we, s_waddr}), 64'({1'b0, 1'b1, 5'd2}));
    end
    set_in(1, 5'd2, 32'h105, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    run_cycle();
    check("starve_forced", 64'({s_stall, s_we, s_waddr, s_wdata}), 64'({1'b1, 1'b1, 5'd11, 32'hB0B}));
    run_cycle();
    check("starve_retry", 64'({s_stall, s_we, s_waddr, s_wdata}), 64'({1'b0, 1'b1, 5'd2, 32'h105}));

    // Full FIFO with pipeline busy, no push-through on the forced pop.
    set_in(1, 5'd3, 32'h30, 1, 5'd12, 32'hC1, 5'd0, 5'd0, 5'd0); run_cycle();
    set_in(1, 5'd3, 32'h31, 1, 5'd13, 32'hC2, 5'd0, 5'd0, 5'd0); run_cycle();
    set_in(1, 5'd3, 32'h32, 1, 5'd14, 32'hC3, 5'd0, 5'd0, 5'd0); run_cycle();
    check("full_ready_c3", 64'(s_ready), 64'd0);
    run_cycle();
    check("full_ready_c4", 64'(s_ready), 64'd0);
    run_cycle();
    run_cycle();
    check("full_forced_pop", 64'({s_stall, s_ready, s_waddr, s_wdata}), 64'({1'b1, 1'b0, 5'd12, 32'hC1}));
    run_cycle();
    check("full_ready_after", 64'({s_ready, s_stall, s_waddr}), 64'({1'b1, 1'b0, 5'd3}));
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd14, 5'd0);
    run_cycle();
    check("full_order_1", 64'({s_we, s_waddr, s_wdata, s_p2}), 64'({1'b1, 5'd13, 32'hC2, 1'b1}));
    run_cycle();
    check("full_order_2", 64'({s_we, s_waddr, s_wdata}), 64'({1'b1, 5'd14, 32'hC3}));
    run_cycle();
    check("full_drained", 64'(s_we), 64'd0);

    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
             5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      run_cycle();
    end
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) run_cycle();

    // Reset in the middle of a drain with two entries buffered.
    set_in(1, 5'd3, 32'h40, 1, 5'd20, 32'hA0, 5'd0, 5'd0, 5'd0); run_cycle();
    set_in(1, 5'd3, 32'h41, 1, 5'd21, 32'hA1, 5'd0, 5'd0, 5'd0); run_cycle();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd21, 5'd0);
    #1;
    check("pre_reset_pend", 64'({rs1_pending, rs2_pending, rf_we, rf_waddr}), 64'({1'b1, 1'b1, 1'b1, 5'd20}));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    m_q.delete();
    m_age = 0;
    set_in(1, 5'd5, 32'h77, 1, 5'd6, 32'h66, 5'd20, 5'd21, 5'd6);
    #1;
    check_reset_outputs("reset_mid_busy");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd21, 5'd0);
    run_cycle();
    check("post_reset", 64'({s_we, s_ready, s_stall, s_p1, s_p2}), 64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (the MEM/WB stage output) and results returning from a long-latency unit (LLU: mul/div, late load return).
- Pipeline writeback has priority. LLU results are buffered in a small FIFO and drained on idle writeback cycles.
- A starvation counter forces a one-cycle pipeline stall when the FIFO head has waited too long.
- Pending-destination lookups feed the ID-stage hazard unit.

Parameters:
- DEPTH, 2: LLU result FIFO entries; power of 2, >= 2.
- MAX_WAIT, 4: cycles the FIFO head may wait before stall_req is asserted; >= 1.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_wb_en  in  1  pipeline writeback wants to write (MEM/WB regwrite bit)
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  XLEN  pipeline writeback data
- llu_valid  in  1  LLU result valid
- llu_rd  in  5  LLU destination register
- llu_data  in  XLEN  LLU result data
- llu_ready  out  1  arbiter accepts an LLU result this cycle
- q_rs1  in  5  ID-stage rs1 lookup
- q_rs2  in  5  ID-stage rs2 lookup
- q_rd  in  5  ID-stage rd lookup (WAW check)
- rs1_pending  out  1  q_rs1 has an unwritten LLU result
- rs2_pending  out  1  q_rs2 has an unwritten LLU result
- rd_pending  out  1  q_rd has an unwritten LLU result
- stall_req  out  1  freeze IF..MEM/WB for this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; read/write pointers and count = 0; age counter = 0.
  - While rst_n is low, force rf_we=0, stall_req=0, llu_ready=0, all *_pending=0, rf_waddr=0, rf_wdata=0.
  - Reset mid-operation discards all buffered LLU results.
- FIFO:
  - Entries hold {rd, data}.
  - llu_ready = !full, combinational from registered count.
  - Push on llu_valid && llu_ready, except llu_rd==0: the handshake completes, nothing is stored.
  - Pointers wrap modulo DEPTH. count is in 0..DEPTH.
  - When full, llu_ready=0 even if a pop occurs the same cycle (no push-through).
  - Push and pop in the same cycle with 0<count<DEPTH: count unchanged.
- Age counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Cleared on pop or when the FIFO is empty.
  - Saturates at MAX_WAIT; width $clog2(MAX_WAIT+1).
- stall_req = (age == MAX_WAIT) && !empty. Combinational from registers; lasts exactly the cycle of the forced pop, because the pop clears age.
- Grant (combinational, same cycle, zero latency):
  1. stall_req=1: write the FIFO head and pop. The pipeline write is suppressed; upstream holds MEM/WB, so it is retried next cycle.
  2. Otherwise, if pipe_wb_en && pipe_rd!=0: write the pipeline value. The FIFO does not pop, so age may grow.
  3. Otherwise, if !empty: write the FIFO head and pop.
  4. Otherwise rf_we=0.
- pipe_wb_en with pipe_rd==0 never writes and counts as an idle cycle for draining.
- rf_waddr/rf_wdata:
  - When a write is granted, carry the granted source.
  - When rf_we=0, rf_waddr=0 and rf_wdata=0.
- Pending lookup:
  - x_pending=1 if the query register is non-zero and matches any valid FIFO entry, or matches llu_rd while llu_valid && llu_ready this cycle.
  - A query of register 0 is never pending.
- WAW: the ID stage must not issue an instruction whose rd is rd_pending. Under that rule, a same-cycle pipeline write and FIFO head to the same rd cannot occur; the arbiter does not check for it.

Decomposition:
- Package wb_arb_pkg:
  - typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - constant REG_ZERO = 5'd0
- Sub-module wb_result_fifo (DEPTH):
  - Push/pop, full/empty, head, and a flat valid/rd vector for the pending compare.
- Arbitration, age counter and lookup comparators live in the top module.

Test Plan:
- Reset release, idle: rf_we=0, llu_ready=1, stall_req=0. Assert rst_n low mid-drain with 2 entries buffered -> FIFO empties, outputs zero immediately.
- Pipeline only: pipe_wb_en=1, pipe_rd=5, pipe_data=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. With pipe_rd=0 -> rf_we=0.
- LLU result llu_rd=7, data=0xCAFE while pipeline idle -> pushed; next cycle rf_waddr=7, rf_wdata=0xCAFE; q_rs1=7 pending only during the buffered cycle.
- Starvation: one buffered entry plus pipeline writing every cycle (MAX_WAIT=4) -> pipeline writes for 4 cycles, 5th cycle stall_req=1 and FIFO head written, next cycle stall_req=0 and the held pipeline write completes.
- Full FIFO (2 entries), llu_valid held with pipeline busy -> llu_ready=0, no overwrite. After a pop, llu_ready=1 the following cycle; drained order matches push order.
- llu_rd=0 with llu_valid=1 -> llu_ready=1, count unchanged, no write ever issued. Query of register 0 is never pending.
